// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage.
// Owns the fetch PC and offers it to IF through a valid/ready handshake.
// Traps have priority over branch/jump redirects, which have priority over
// sequential advance. The block also supports halt/resume, flags misaligned
// redirect targets, and keeps a saturating count of applied redirects.
//
// state   | meaning
// --------+------------------------------------------------------------
// BOOT    | first cycle after reset; pc = RESET_PC, no fetch offered
// RUN     | pc offered to IF (pc_valid=1); trap/redirect/advance applied
// HALT    | fetch stopped (pc_valid=0); redirect updates pc, trap or
//         | resume returns to RUN
module pc_gen #(
    parameter int                WIDTH      = 32,
    parameter int                STEP       = 4,
    parameter int                ALIGN_BITS = 2,
    parameter logic [WIDTH-1:0]  RESET_PC   = WIDTH'(32'h1c00_0000),
    parameter int                CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 pc_ready,
    input  logic                 redirect_valid,
    input  logic [WIDTH-1:0]     redirect_pc,
    input  logic                 trap_valid,
    input  logic [WIDTH-1:0]     trap_vec,
    input  logic                 halt_req,
    input  logic                 resume,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     npc,
    output logic                 pc_valid,
    output logic                 halted,
    output logic                 misalign_err,
    output logic [CNT_WIDTH-1:0] redirect_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Low PC bits that must be zero in any fetch address.
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     pc_q, pc_d;
    logic                 mis_q, mis_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 apply_tgt;
    logic [WIDTH-1:0]     target;

    // Trap target wins over the branch target when both arrive together.
    assign target = trap_valid ? trap_vec : redirect_pc;
    assign npc    = pc_q + WIDTH'(STEP);

    // Next-state, next-pc and statistics update.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mis_d     = 1'b0;
        cnt_d     = cnt_q;
        apply_tgt = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (trap_valid || redirect_valid) begin
                    apply_tgt = 1'b1;
                end else if (pc_ready) begin
                    pc_d = npc;
                end
                if (halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (trap_valid || redirect_valid) begin
                    apply_tgt = 1'b1;
                end
                // A trap always restarts fetch; resume beats a repeated halt_req.
                if (trap_valid || resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        if (apply_tgt) begin
            pc_d  = target & ~LOW_MASK;
            mis_d = |(target & LOW_MASK);
            if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // State and output registers; reset drops any pending redirect at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = (state_q == ST_RUN);
    assign halted       = (state_q == ST_HALT);
    assign misalign_err = mis_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage; successor to the fixed pc+4 incrementer.
- Owns the PC register and presents the fetch address to IF through a valid/ready handshake.
- Applies trap and branch/jump redirects with fixed priority, supports halt/resume, flags misaligned targets, and counts redirects.

Parameters:
- WIDTH, 32, PC width in bits.
- STEP, 4, byte increment per accepted fetch; must be a power of two.
- ALIGN_BITS, 2, low PC bits forced to zero; equals log2(STEP).
- RESET_PC, 32'h1c00_0000, PC value loaded on reset.
- CNT_WIDTH, 16, width of the redirect statistics counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- pc_ready  in  1  IF accepts the current pc this cycle.
- redirect_valid  in  1  branch/jump redirect request from EX.
- redirect_pc  in  WIDTH  redirect target.
- trap_valid  in  1  exception/interrupt entry request.
- trap_vec  in  WIDTH  trap handler address.
- halt_req  in  1  request to stop fetching.
- resume  in  1  leave HALT.
- pc  out  WIDTH  current fetch address (registered).
- npc  out  WIDTH  pc + STEP, combinational, modulo 2^WIDTH.
- pc_valid  out  1  pc is a valid fetch request.
- halted  out  1  FSM is in HALT.
- misalign_err  out  1  one-cycle pulse: the accepted target had nonzero low ALIGN_BITS.
- redirect_cnt  out  CNT_WIDTH  count of applied trap and redirect events; saturates at the maximum value.

Behaviour:
- Reset (asynchronous, rstn=0): pc=RESET_PC, pc_valid=0, halted=0, misalign_err=0, redirect_cnt=0, state=BOOT. Reset asserted mid-operation drops everything immediately, including a pending redirect.
- FSM states: BOOT, RUN, HALT.
- BOOT: lasts exactly one cycle after reset release, then goes to RUN with pc_valid=1. pc holds RESET_PC. redirect_valid and trap_valid are ignored in BOOT.
- RUN: priority per cycle is trap_valid > redirect_valid > handshake advance.
  - trap_valid=1: pc <= trap_vec with low ALIGN_BITS cleared, regardless of pc_ready. The current pc is dropped, pc_valid stays 1, redirect_cnt+1.
  - Else redirect_valid=1: pc <= redirect_pc with low ALIGN_BITS cleared, regardless of pc_ready. redirect_cnt+1.
  - Else pc_valid && pc_ready: pc <= pc + STEP. All-ones wraps to 0, with no error.
  - Else: pc holds (stall).
  - halt_req=1: next state HALT, pc_valid <= 0. A trap or redirect in the same cycle is still applied to pc before halting. A plain advance is still applied if the handshake completed that cycle.
- HALT: halted=1, pc_valid=0.
  - trap_valid: updates pc and returns to RUN (pc_valid=1 next cycle).
  - redirect_valid: updates pc and stays in HALT.
  - resume: returns to RUN with pc_valid=1 next cycle.
  - halt_req together with resume: resume wins.
- misalign_err: registered, high for exactly the one cycle after an applied target (trap or redirect) whose low ALIGN_BITS were nonzero. Only the applied target is checked; a target discarded by priority is not.
- redirect_cnt: increments once per applied trap or redirect; a simultaneous trap and redirect counts 1. Holds at 2^CNT_WIDTH-1.
- npc follows pc combinationally in every state.
- pc is registered, so a redirect is visible on pc the cycle after redirect_valid is asserted.

Test Plan:
- Reset then release with pc_ready=1 for 4 cycles -> pc_valid=0 in BOOT; then pc = 1c000000, 1c000004, 1c000008, 1c00000c; npc is always pc+4.
- pc_ready=0 for 3 cycles at pc=1c000010 -> pc holds 1c000010; pc_ready=1 -> next pc=1c000014.
- Same cycle: trap_valid, trap_vec=00000100, redirect_valid, redirect_pc=1c000200 -> pc=00000100, redirect_cnt+1 only, misalign_err=0.
- redirect_pc=1c000202 -> pc=1c000200, misalign_err=1 for exactly one cycle.
- halt_req at pc=1c000020, then redirect_pc=1c000300 while halted -> halted=1, pc=1c000300, pc_valid=0.
  - Then resume -> pc_valid=1 at 1c000300.
- WIDTH=8, STEP=4, pc=fc, pc_ready=1 -> pc wraps to 00.
- CNT_WIDTH=2: 5 redirects -> redirect_cnt=3.
- rstn low mid-redirect -> outputs take reset values asynchronously, with no clock edge required.
